// File: rtl/hazard_sched_pkg.sv
// Shared definitions for the pipeline hazard scheduler.
//   state_t   : sequencer state of the single multi-cycle (MULT/DIV) unit
//   REG_W     : default register-index width
//   NUM_REGS  : number of architectural registers (width of busy_vec)
//   ZERO_REG  : hard-wired zero register, never a hazard source
package hazard_sched_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_MC_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_compare.sv
// Combinational register-match logic for the hazard scheduler.
// Ports:
//   id_valid, id_rs, id_rt, id_rd : instruction currently in ID
//   ex_memread, ex_rt             : load in EX and its destination
//   mc_pending, mc_rd             : multi-cycle op in flight and its destination
//   load_use                      : ID reads the register the EX load writes
//   raw_mc                        : ID reads or writes the pending multi-cycle
//                                   destination (RAW and WAW)
module hazard_compare #(
    parameter int REG_W = hazard_sched_pkg::REG_W
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             mc_pending,
    input  logic [REG_W-1:0] mc_rd,
    output logic             load_use,
    output logic             raw_mc
);
    import hazard_sched_pkg::*;

    localparam logic [REG_W-1:0] ZERO = REG_W'(ZERO_REG);

    always_comb begin
        load_use = id_valid && ex_memread && (ex_rt != ZERO) &&
                   ((ex_rt == id_rs) || (ex_rt == id_rt));
        // id_rd is included so a younger write cannot land before the
        // older multi-cycle result overwrites it.
        raw_mc   = id_valid && mc_pending && (mc_rd != ZERO) &&
                   ((mc_rd == id_rs) || (mc_rd == id_rt) || (mc_rd == id_rd));
    end

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline-control sequencer for the 5-stage core: load-use stall, branch
// flush, issue/tracking of one non-pipelined multi-cycle unit and arbitration
// of the regfile write port between WB and the multi-cycle result.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   id_* / ex_* / wb_regwrite: pipeline status inputs
//   pc_we, ifid_we           : front-end enables (0 while stalling)
//   ifid_flush, idex_bubble  : flush IF/ID, insert NOP into ID/EX
//   mc_issue                 : start multi-cycle op this cycle
//   mc_wb_valid, mc_wb_rd    : multi-cycle result owns the write port
//   busy_vec                 : one-hot pending multi-cycle destination
// Outputs are combinational from registered state and current inputs.
module hazard_scheduler #(
    parameter int MC_LAT = 4,
    parameter int REG_W  = hazard_sched_pkg::REG_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  id_valid,
    input  logic [REG_W-1:0]                      id_rs,
    input  logic [REG_W-1:0]                      id_rt,
    input  logic [REG_W-1:0]                      id_rd,
    input  logic                                  id_is_mc,
    input  logic                                  ex_memread,
    input  logic [REG_W-1:0]                      ex_rt,
    input  logic                                  ex_branch_taken,
    input  logic                                  wb_regwrite,
    output logic                                  pc_we,
    output logic                                  ifid_we,
    output logic                                  ifid_flush,
    output logic                                  idex_bubble,
    output logic                                  mc_issue,
    output logic                                  mc_wb_valid,
    output logic [REG_W-1:0]                      mc_wb_rd,
    output logic [hazard_sched_pkg::NUM_REGS-1:0] busy_vec
);
    import hazard_sched_pkg::*;

    localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam logic [REG_W-1:0] ZERO = REG_W'(ZERO_REG);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [REG_W-1:0]   mc_rd;
    logic               mc_pending;
    logic               load_use, raw_mc, struct_haz, drain, stall;

    assign mc_pending = (state != ST_IDLE);

    hazard_compare #(.REG_W(REG_W)) u_cmp (
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .mc_pending (mc_pending),
        .mc_rd      (mc_rd),
        .load_use   (load_use),
        .raw_mc     (raw_mc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            mc_rd <= '0;
        end else begin
            state <= state_nx;
            if (mc_issue) begin
                mc_rd <= id_rd;
                cnt   <= CNT_W'(MC_LAT - 1);
            end else if (state == ST_MC_BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (mc_issue)     state_nx = ST_MC_BUSY;
            ST_MC_BUSY: if (cnt == '0)    state_nx = ST_MC_WB;
            // WB always owns the port; the result waits here until it is free.
            ST_MC_WB:   if (!wb_regwrite) state_nx = ST_IDLE;
            default:                      state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        struct_haz  = id_valid && id_is_mc && mc_pending;
        // Freeze the front end while the result drains so the bubbles ahead
        // of it reach WB; the wait is short because WB frees up.
        drain       = id_valid && (state == ST_MC_WB);
        stall       = load_use || raw_mc || struct_haz || drain;

        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end

        mc_issue    = id_valid && id_is_mc && (state == ST_IDLE) &&
                      !stall && !ex_branch_taken;
        mc_wb_valid = (state == ST_MC_WB) && !wb_regwrite;
        mc_wb_rd    = mc_pending ? mc_rd : ZERO;
        busy_vec    = '0;
        if (mc_pending && mc_rd != ZERO)
            busy_vec = NUM_REGS'(1) << mc_rd;
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;
    localparam int MC_LAT = 4;
    localparam int REG_W  = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic             id_is_mc = 1'b0;
    logic             ex_memread = 1'b0;
    logic [REG_W-1:0] ex_rt = '0;
    logic             ex_branch_taken = 1'b0;
    logic             wb_regwrite = 1'b0;
    logic             pc_we, ifid_we, ifid_flush, idex_bubble, mc_issue, mc_wb_valid;
    logic [REG_W-1:0] mc_wb_rd;
    logic [31:0]      busy_vec;

    hazard_scheduler #(.MC_LAT(MC_LAT), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_is_mc(id_is_mc), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .wb_regwrite(wb_regwrite),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .mc_issue(mc_issue), .mc_wb_valid(mc_wb_valid),
        .mc_wb_rd(mc_wb_rd), .busy_vec(busy_vec)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The multi-cycle op is tracked by time: it becomes eligible to write at
    // issue_cycle + MC_LAT + 1 and stays pending until it actually writes.
    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;
    bit               m_pend = 0;
    int               m_ready_at = 0;
    logic [REG_W-1:0] m_dst = '0;
    bit               e_issue, e_wbv;
    logic [REG_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0;
        m_dst  = '0;
        exp_q.delete();
    endtask

    task automatic check_all();
        bit in_wb, lu, raw, st, dr, stall, fl;
        logic [31:0] e_busy;
        in_wb = m_pend && (cyc >= m_ready_at);
        lu    = id_valid && ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
        raw   = id_valid && m_pend && m_dst != 0 &&
                (m_dst == id_rs || m_dst == id_rt || m_dst == id_rd);
        st    = id_valid && id_is_mc && m_pend;
        dr    = id_valid && in_wb;
        stall = lu || raw || st || dr;
        fl    = ex_branch_taken;
        e_issue = id_valid && id_is_mc && !m_pend && !stall && !fl;
        e_wbv   = in_wb && !wb_regwrite;
        e_busy  = (m_pend && m_dst != 0) ? (32'd1 << m_dst) : 32'd0;
        check("pc_we",       {31'd0, pc_we},       {31'd0, fl || !stall});
        check("ifid_we",     {31'd0, ifid_we},     {31'd0, fl || !stall});
        check("ifid_flush",  {31'd0, ifid_flush},  {31'd0, fl});
        check("idex_bubble", {31'd0, idex_bubble}, {31'd0, fl || stall});
        check("mc_issue",    {31'd0, mc_issue},    {31'd0, e_issue});
        check("mc_wb_valid", {31'd0, mc_wb_valid}, {31'd0, e_wbv});
        check("mc_wb_rd",    32'(mc_wb_rd),        m_pend ? 32'(m_dst) : 32'd0);
        check("busy_vec",    busy_vec,             e_busy);
        // scoreboard: every write-back must match the oldest issued destination
        if (mc_wb_valid === 1'b1) begin
            if (exp_q.size() == 0) check("sb_unexpected_wb", 32'd1, 32'd0);
            else                   check("sb_wb_rd", 32'(mc_wb_rd), 32'(exp_q.pop_front()));
        end
    endtask

    // One cycle: settle, compare, clock, advance the model. Returns at negedge.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        if (e_wbv) m_pend = 0;
        if (e_issue) begin
            m_pend     = 1;
            m_dst      = id_rd;
            m_ready_at = cyc + MC_LAT + 1;
            exp_q.push_back(id_rd);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_is_mc = 0;
        ex_memread = 0; ex_rt = 0; ex_branch_taken = 0; wb_regwrite = 0;
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        #1;
        model_reset();
        check("rst_busy_vec", busy_vec, 32'd0);
        check("rst_pc_we", {31'd0, pc_we}, 32'd1);
        check("rst_wb_valid", {31'd0, mc_wb_valid}, 32'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 0;
    endtask

    function automatic logic [REG_W-1:0] rand_reg();
        case ($urandom_range(0, 5))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            3: return 5'd8;
            default: return REG_W'($urandom_range(0, 31));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        apply_reset();

        // 1: load-use stall, then same with ex_rt=0
        id_valid = 1; id_rs = 5; id_rt = 3; ex_memread = 1; ex_rt = 5;
        #1; check("t1_stall_pc_we", {31'd0, pc_we}, 32'd0);
        tick();
        ex_rt = 0; id_rs = 0;
        #1; check("t1_r0_pc_we", {31'd0, pc_we}, 32'd1);
        tick();
        idle_inputs();

        // 2+3: issue rd=8, id_rs=8 from cycle1, second mc at cycle2
        id_valid = 1; id_is_mc = 1; id_rd = 8; id_rs = 1; id_rt = 2;
        #1; check("t2_issue", {31'd0, mc_issue}, 32'd1);
        tick();
        id_is_mc = 0; id_rs = 8; id_rd = 3;
        #1; check("t2_busy1", busy_vec, 32'h100);
        tick();
        id_is_mc = 1; id_rd = 4;
        for (int i = 2; i <= 4; i++) tick();
        #1; check("t2_wb_rd", 32'(mc_wb_rd), 32'd8);
        tick();
        #1; check("t2_busy_clear", busy_vec, 32'd0);
        check("t3_issue6", {31'd0, mc_issue}, 32'd1);
        tick();
        idle_inputs();
        for (int i = 0; i < MC_LAT + 2; i++) tick();

        // 4: WB owns the port for two cycles while the result waits
        id_valid = 1; id_is_mc = 1; id_rd = 9;
        tick();
        idle_inputs();
        for (int i = 0; i < MC_LAT; i++) tick();
        id_valid = 1; id_rs = 1; wb_regwrite = 1;
        tick();
        #1; check("t4_wait_wb_valid", {31'd0, mc_wb_valid}, 32'd0);
        tick();
        wb_regwrite = 0;
        #1; check("t4_wb_valid", {31'd0, mc_wb_valid}, 32'd1);
        tick();
        idle_inputs();
        tick();

        // 5: branch beats load-use
        id_valid = 1; id_rs = 6; ex_memread = 1; ex_rt = 6; ex_branch_taken = 1; id_is_mc = 1;
        #1; check("t5_flush", {31'd0, ifid_flush}, 32'd1);
        tick();
        idle_inputs();

        // 6: reset during MC_BUSY, then a fresh op
        id_valid = 1; id_is_mc = 1; id_rd = 12;
        tick();
        idle_inputs();
        tick(); tick();
        apply_reset();
        for (int i = 0; i < MC_LAT + 2; i++) tick();
        id_valid = 1; id_is_mc = 1; id_rd = 13;
        tick();
        idle_inputs();
        for (int i = 0; i < MC_LAT + 2; i++) tick();

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
            end else begin
                id_valid        = ($urandom_range(0, 9) != 0);
                id_rs           = rand_reg();
                id_rt           = rand_reg();
                id_rd           = rand_reg();
                id_is_mc        = ($urandom_range(0, 3) == 0);
                ex_memread      = ($urandom_range(0, 3) == 0);
                ex_rt           = rand_reg();
                ex_branch_taken = ($urandom_range(0, 9) == 0);
                wb_regwrite     = ($urandom_range(0, 1) == 1);
                tick();
            end
        end
        idle_inputs();
        for (int i = 0; i < MC_LAT + 3; i++) tick();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
